// File: rtl/seg7_pkg.sv
// Shared display codes, segment patterns and the code-to-segment encoder.
package seg7_pkg;

    // Non-numeric display codes carried on the 4-bit code path
    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_R     = 4'hC;
    localparam logic [3:0] CODE_MINUS = 4'hF;

    // Segment patterns, a..g with a in the MSB, active low
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_R     = 7'b1111010;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Map a display code to its active-low segment pattern
    function automatic logic [6:0] seg7_encode(input logic [3:0] code);
        case (code)
            4'h0:       return SEG_0;
            4'h1:       return SEG_1;
            4'h2:       return SEG_2;
            4'h3:       return SEG_3;
            4'h4:       return SEG_4;
            4'h5:       return SEG_5;
            4'h6:       return SEG_6;
            4'h7:       return SEG_7;
            4'h8:       return SEG_8;
            4'h9:       return SEG_9;
            CODE_E:     return SEG_E;
            CODE_R:     return SEG_R;
            CODE_MINUS: return SEG_MINUS;
            default:    return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_sel.sv
// Combinational per-digit code selection: error message, invalid BCD,
// sign placement and leading-zero suppression for the digit at idx.
module seg7_digit_sel
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4
) (
    input  logic [4*N_DIGITS-1:0]       digits,
    input  logic [N_DIGITS-1:0]         dp_mask,
    input  logic                        neg,
    input  logic                        error,
    input  logic                        lz_en,
    input  logic [$clog2(N_DIGITS)-1:0] idx,
    output logic [3:0]                  code_c,
    output logic                        dp_on_c
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0] ERR_R1  = IDX_W'(N_DIGITS - 2);
    localparam logic [IDX_W-1:0] ERR_R2  = IDX_W'(N_DIGITS - 3);

    logic [3:0]          nib [N_DIGITS];
    logic [N_DIGITS-1:0] lz_blank;
    logic                chain;
    logic [IDX_W-1:0]    msd;
    logic [IDX_W-1:0]    minus_pos;
    logic [3:0]          nib_sel;

    // Unpack the nibble bus into one entry per digit
    for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_nib
        assign nib[g] = digits[4*g +: 4];
    end

    // Blank the contiguous run of zero digits from the left; digit 0 always shows
    always_comb begin
        lz_blank = '0;
        chain    = lz_en;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            if (chain && (nib[i] == 4'd0) && !dp_mask[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Highest digit left visible after suppression
    always_comb begin
        msd = '0;
        for (int i = 1; i < int'(N_DIGITS); i++) begin
            if (!lz_blank[i]) begin
                msd = IDX_W'(i);
            end
        end
    end

    // Minus hugs the number when suppressing, otherwise takes the leftmost digit
    assign minus_pos = (lz_en && (msd != TOP_IDX)) ? msd + 1'b1 : TOP_IDX;
    assign nib_sel   = nib[idx];

    // Priority-ordered code selection for the addressed digit
    always_comb begin
        code_c  = nib_sel;
        dp_on_c = dp_mask[idx] & ~error;
        if (error) begin
            if (idx == TOP_IDX) begin
                code_c = CODE_E;
            end else if ((idx == ERR_R1) || (idx == ERR_R2)) begin
                code_c = CODE_R;
            end else begin
                code_c = CODE_BLANK;
            end
        end else if (nib_sel > 4'd9) begin
            code_c = CODE_BLANK;
        end else if (neg && (idx == minus_pos)) begin
            code_c = CODE_MINUS;
        end else if (lz_blank[idx]) begin
            code_c = CODE_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver with per-frame input
// snapshot, PWM brightness and frame-based blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV  = 262144,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    neg,
    input  logic                    error,
    input  logic                    lz_en,
    input  logic                    blink_en,
    input  logic [3:0]              brightness,
    output logic [N_DIGITS-1:0]     anode,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned SLOT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W   = $clog2(N_DIGITS);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Extra headroom so the full-scale product 16*REFRESH_DIV cannot wrap
    localparam int unsigned THR_W   = SLOT_W + 5;

    localparam logic [IDX_W-1:0]   TOP_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  frame_start_c;

    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic                  snap_neg;
    logic                  snap_error;
    logic                  snap_lz;
    logic [3:0]            snap_bright;

    logic [BLINK_W-1:0]    blink_cnt;
    logic                  phase;

    logic [SLOT_W-1:0]     slot_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  valid_q;

    logic [THR_W-1:0]      thr_c;
    logic                  slot_on_c;
    logic [3:0]            code_c;
    logic                  dp_on_c;

    assign frame_start_c = (idx == TOP_IDX) && (slot_cnt == '0);

    // Slot timer and digit index, scanning from the leftmost digit down to 0
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            idx      <= TOP_IDX;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            idx      <= (idx == '0) ? TOP_IDX : idx - 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Capture a coherent copy of the display inputs once per frame
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_neg    <= 1'b0;
            snap_error  <= 1'b0;
            snap_lz     <= 1'b0;
            snap_bright <= '0;
        end else if (frame_start_c) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
            snap_neg    <= neg;
            snap_error  <= error;
            snap_lz     <= lz_en;
            snap_bright <= brightness;
        end
    end

    // Blink frame counter; held cleared while blinking is off
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_start_c) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Delay the scan position one cycle so it lines up with the fresh snapshot
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_cnt;
            idx_q   <= idx;
            valid_q <= 1'b1;
        end
    end

    seg7_digit_sel #(
        .N_DIGITS (N_DIGITS)
    ) u_digit_sel (
        .digits  (snap_digits),
        .dp_mask (snap_dp),
        .neg     (snap_neg),
        .error   (snap_error),
        .lz_en   (snap_lz),
        .idx     (idx_q),
        .code_c  (code_c),
        .dp_on_c (dp_on_c)
    );

    assign thr_c     = ((THR_W'(snap_bright) + THR_W'(1)) * THR_W'(REFRESH_DIV)) >> 4;
    assign slot_on_c = THR_W'(slot_q) < thr_c;

    // Registered pin drivers: anode gated by PWM and blink, segments from the code
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            if (!valid_q || (blink_en && phase) || !slot_on_c) begin
                anode <= '1;
            end else begin
                anode <= ~(N_DIGITS'(1) << idx_q);
            end
            seg <= valid_q ? seg7_encode(code_c) : SEG_BLANK;
            dp  <= valid_q ? ~dp_on_c : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (N=4, REFRESH_DIV=16, BLINK_FRAMES=2).
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 16;
    localparam int BF    = 2;
    localparam int FRAME = N * RD;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        neg = 1'b0;
    logic        error = 1'b0;
    logic        lz_en = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  brightness = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ecount  = 0;
    int          m_cnt   = 0;
    logic        m_phase = 1'b0;
    string       cur_tag = "init";
    logic [11:0] exp_q[$];

    always #5 clock = ~clock;

    seg7_scan_driver #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .neg        (neg),
        .error      (error),
        .lz_en      (lz_en),
        .blink_en   (blink_en),
        .brightness (brightness),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got anode=%b seg=%b dp=%b, want anode=%b seg=%b dp=%b",
                     tag, ecount, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    // Symbols: 0..9 digits, 10 blank, 11 E, 12 r, 13 minus
    function automatic logic [6:0] seg_of(input int sym);
        case (sym)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            11: return 7'b0110000;
            12: return 7'b1111010;
            13: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {anode, seg, dp} at frame position p for a given snapshot
    function automatic logic [11:0] exp_out(input logic [15:0] dig, input logic [3:0] dpm,
                                            input logic ng, input logic er, input logic lz,
                                            input logic [3:0] br, input int p);
        int         d;
        int         s;
        int         nib;
        int         msd;
        int         mpos;
        int         sym;
        logic [3:0] an;
        logic       dpo;
        d   = (N - 1) - p / RD;
        s   = p % RD;
        an  = (s < int'(br) + 1) ? ~(4'b0001 << d) : 4'hF;
        nib = int'(dig[4*d +: 4]);
        msd = N - 1;
        if (lz) begin
            msd = 0;
            for (int i = N - 1; i >= 1; i--) begin
                if (dig[4*i +: 4] != 4'd0 || dpm[i]) begin
                    msd = i;
                    break;
                end
            end
        end
        mpos = (lz && msd < N - 1) ? msd + 1 : N - 1;
        if (er)                      sym = (d == N - 1) ? 11 : (d == N - 2 || d == N - 3) ? 12 : 10;
        else if (nib >= 10)          sym = 10;
        else if (ng && d == mpos)    sym = 13;
        else if (lz && d > msd)      sym = 10;
        else                         sym = nib;
        dpo = (dpm[d] && !er) ? 1'b0 : 1'b1;
        return {an, seg_of(sym), dpo};
    endfunction

    // One clock: queue a frame of expectations at frame start, then compare one output
    task automatic step();
        logic        fs;
        logic        blank_now;
        logic [11:0] want;
        fs = (ecount % FRAME == 0);
        if (fs) begin
            for (int p = 0; p < FRAME; p++) begin
                exp_q.push_back(exp_out(digits_in, dp_in, neg, error, lz_en, brightness, p));
            end
        end
        blank_now = blink_en && m_phase;
        if (!blink_en) begin
            m_cnt   = 0;
            m_phase = 1'b0;
        end else if (fs) begin
            if (m_cnt == BF - 1) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clock);
        ecount++;
        @(negedge clock);
        want = exp_q.pop_front();
        if (blank_now) want[11:8] = 4'hF;
        check_eq(cur_tag, {anode, seg, dp}, want);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Scan restarts after reset release: first output is still blank
    task automatic restart_model();
        ecount = 0;
        exp_q.delete();
        exp_q.push_back(12'hFFF);
        m_cnt   = 0;
        m_phase = 1'b0;
    endtask

    initial begin
        // Reset held: outputs stay blank regardless of inputs
        rst = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check_eq("reset_hold", {anode, seg, dp}, 12'hFFF);
            digits_in  = 16'($urandom);
            dp_in      = 4'($urandom);
            neg        = 1'($urandom);
            error      = 1'($urandom);
            brightness = 4'($urandom);
        end

        // Plain display, captured at the first frame start after release
        digits_in = 16'h1234; dp_in = 4'b0100; neg = 1'b0; error = 1'b0;
        lz_en = 1'b0; blink_en = 1'b0; brightness = 4'd15;
        cur_tag = "plain";
        rst = 1'b0;
        restart_model();
        run(2 * FRAME);

        cur_tag = "lz_neg";
        digits_in = 16'h0007; dp_in = 4'b0000; lz_en = 1'b1; neg = 1'b1;
        run(FRAME);

        cur_tag = "lz_dp";
        dp_in = 4'b0100; neg = 1'b0;
        run(FRAME);

        cur_tag = "lz_zero_neg";
        digits_in = 16'h0000; dp_in = 4'b0000; neg = 1'b1;
        run(FRAME);

        cur_tag = "lz_invalid";
        digits_in = 16'h00B5; neg = 1'b0;
        run(FRAME);

        cur_tag = "neg_no_lz";
        digits_in = 16'h0042; lz_en = 1'b0; neg = 1'b1;
        run(FRAME);

        cur_tag = "error";
        digits_in = 16'h9999; dp_in = 4'b1111; error = 1'b1; neg = 1'b1;
        run(FRAME);

        // Dim setting plus a mid-frame input change that must not tear
        cur_tag = "bright_snap";
        digits_in = 16'h1234; dp_in = 4'b0001; error = 1'b0; neg = 1'b0; brightness = 4'd3;
        run(30);
        digits_in = 16'h5678; brightness = 4'd7;
        run(FRAME - 30);
        run(FRAME);

        // Blinking: steady alternation, then release while dark
        cur_tag = "blink";
        brightness = 4'd15;
        blink_en = 1'b1;
        run(6 * FRAME);
        for (int k = 0; k < 4 * FRAME && !m_phase; k++) step();
        run(20);
        cur_tag = "blink_off";
        blink_en = 1'b0;
        run(FRAME);

        // Asynchronous reset in the middle of a frame
        cur_tag = "async_rst";
        run(20);
        #2 rst = 1'b1;
        #1 check_eq("async_rst_now", {anode, seg, dp}, 12'hFFF);
        @(negedge clock);
        check_eq("async_rst_hold", {anode, seg, dp}, 12'hFFF);
        rst = 1'b0;
        restart_model();
        cur_tag = "after_rst";
        run(FRAME + 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
